// File: rtl/even_odd_fsm.sv
// Registered parity classifier: IDLE/EVEN/ODD FSM driven by the LSB of each valid sample.
// Optional saturating even/odd sample counters are compiled in with `define EVEN_ODD_COUNT_EN.
module even_odd_fsm #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num_in,
  input  logic             valid,
  output logic             is_even,
  output logic             is_odd,
  output logic             out_valid,
  output logic             changed,
`ifdef EVEN_ODD_COUNT_EN
  output logic [CNT_W-1:0] even_cnt,
  output logic [CNT_W-1:0] odd_cnt,
`endif
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_out_valid;
  logic   r_changed;
  logic   w_out_valid_nxt;
  logic   w_changed_nxt;
  logic   w_sample_odd;

  // Only bit 0 carries the class; the remaining bits are intentionally dropped.
  logic   w_unused_upper;
  assign w_unused_upper = ^num_in;
  assign w_sample_odd   = num_in[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_changed   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_changed   <= w_changed_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = 1'b0;
    w_changed_nxt   = 1'b0;
    case (r_state)
      IDLE, EVEN, ODD: begin
        if (valid) begin
          w_state_nxt     = w_sample_odd ? ODD : EVEN;
          w_out_valid_nxt = 1'b1;
          // The first classification out of IDLE is never a change.
          w_changed_nxt   = (r_state != IDLE) && (w_state_nxt != r_state);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign is_even   = (r_state == EVEN);
  assign is_odd    = (r_state == ODD);
  assign out_valid = r_out_valid;
  assign changed   = r_changed;
  assign state_o   = r_state;

`ifdef EVEN_ODD_COUNT_EN
  logic [CNT_W-1:0] r_even_cnt;
  logic [CNT_W-1:0] r_odd_cnt;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_even_cnt <= '0;
      r_odd_cnt  <= '0;
    end else if (w_out_valid_nxt) begin
      if (!w_sample_odd && (r_even_cnt != {CNT_W{1'b1}}))
        r_even_cnt <= r_even_cnt + 1'b1;
      if (w_sample_odd && (r_odd_cnt != {CNT_W{1'b1}}))
        r_odd_cnt <= r_odd_cnt + 1'b1;
    end
  end

  assign even_cnt = r_even_cnt;
  assign odd_cnt  = r_odd_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_even_odd_fsm.sv
// Bench for even_odd_fsm: directed test-plan steps followed by randomized samples and
// asynchronous resets, checked against a class/counter reference model.
module tb_even_odd_fsm;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] num_in;
  logic             valid;
  logic             is_even;
  logic             is_odd;
  logic             out_valid;
  logic             changed;
  logic [1:0]       state_o;
`ifdef EVEN_ODD_COUNT_EN
  logic [CNT_W-1:0] even_cnt;
  logic [CNT_W-1:0] odd_cnt;
`endif

  even_odd_fsm #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .num_in   (num_in),
    .valid    (valid),
    .is_even  (is_even),
    .is_odd   (is_odd),
    .out_valid(out_valid),
    .changed  (changed),
`ifdef EVEN_ODD_COUNT_EN
    .even_cnt (even_cnt),
    .odd_cnt  (odd_cnt),
`endif
    .state_o  (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec;
  int nerr;

  // Reference model: class 0 = none yet, 1 = even, 2 = odd.
  int m_cls;
  int m_ov;
  int m_ch;
  int m_ec;
  int m_oc;

  task automatic model_reset();
    m_cls = 0; m_ov = 0; m_ch = 0; m_ec = 0; m_oc = 0;
  endtask

  task automatic model_edge(input logic v, input logic [WIDTH-1:0] n);
    int newc;
    if (v) begin
      newc  = (n % 2 == 1) ? 2 : 1;
      m_ch  = (m_cls != 0 && m_cls != newc) ? 1 : 0;
      m_ov  = 1;
      m_cls = newc;
      if (newc == 1 && m_ec < CMAX) m_ec++;
      if (newc == 2 && m_oc < CMAX) m_oc++;
    end else begin
      m_ov = 0;
      m_ch = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".is_even"},   32'(is_even),   32'(m_cls == 1));
    chk({tag, ".is_odd"},    32'(is_odd),    32'(m_cls == 2));
    chk({tag, ".state_o"},   32'(state_o),   32'(m_cls));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".changed"},   32'(changed),   32'(m_ch));
`ifdef EVEN_ODD_COUNT_EN
    chk({tag, ".even_cnt"},  32'(even_cnt),  32'(m_ec));
    chk({tag, ".odd_cnt"},   32'(odd_cnt),   32'(m_oc));
`endif
  endtask

  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] n);
    @(negedge clk);
    valid  = v;
    num_in = n;
    @(posedge clk);
    model_edge(v, n);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges with a sample pending; it must never be classified.
  task automatic async_reset(input string tag);
    #2;
    valid  = 1'b1;
    num_in = WIDTH'($urandom);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".imm"});
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    model_reset();
    rst    = 1'b0;
    valid  = 1'b1;
    num_in = 4'd3;
    #7;
    check_all("reset");
    #3;
    rst   = 1'b1;
    valid = 1'b0;

    step("idle_hold", 1'b0, 4'd5);
    step("s2",        1'b1, 4'd2);
    step("s7",        1'b1, 4'd7);
    step("s6",        1'b1, 4'd6);
    step("s7b",       1'b1, 4'd7);
    step("hold1",     1'b0, 4'd4);
    step("hold2",     1'b0, 4'd4);
    step("b2b0",      1'b1, 4'd0);
    step("b2b8",      1'b1, 4'd8);
    step("b2b15",     1'b1, 4'd15);
    step("after",     1'b0, 4'd15);
    async_reset("areset");

    for (int k = 0; k < 5; k++) step("sat_even", 1'b1, 4'(2 * k));
    step("odd_one", 1'b1, 4'd9);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), WIDTH'($urandom));
      if ($urandom_range(0, 39) == 0) async_reset("rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
